territory_label_scheduler: RTL and testbench

//  Per-scanline scheduler for territory label rendering. During horizontal blanking it scans the territory

---
 rtl/territory_label_scheduler.sv | 164 ++++++++++++++++
 tb/tb_territory_label_scheduler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/territory_label_scheduler.sv
// Per-scanline label scheduler. During horizontal blanking it walks the
// territory table one record per clock, collects up to SLOTS labels whose
// glyph box covers the next line into a shadow buffer, and publishes that
// buffer at the line boundary so the text path only draws those slots.
//
// Handshake/timing contract: there is no valid/ready pair here. The raster
// position (DrawX/DrawY) is the only pacing. Slot outputs are registers that
// change only on the edge that ends DrawX==H_TOTAL-1. scan_done is high for
// exactly the following cycle, which is DrawX==0 of the scheduled line.
module territory_label_scheduler #(
  parameter int NUM_TERR  = 42,
  parameter int SLOTS     = 4,
  parameter int CHAR_H    = 16,
  parameter int H_VISIBLE = 640,
  parameter int H_TOTAL   = 800,
  parameter int V_TOTAL   = 525
) (
  input  logic                      vga_clk,
  input  logic                      reset_n,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic                      setup,
  input  logic                      vic_on,
  input  logic [71*NUM_TERR-1:0]    territories,
  output logic [SLOTS-1:0]          slot_valid,
  output logic [10*SLOTS-1:0]       slot_x,
  output logic [4*SLOTS-1:0]        slot_row,
  output logic [7*SLOTS-1:0]        slot_char,
  output logic [2*SLOTS-1:0]        slot_color,
  output logic [7*SLOTS-1:0]        slot_troops,
  output logic                      scan_done,
  output logic                      overflow,
  output logic [1:0]                state_dbg
);

  localparam int IW = $clog2(NUM_TERR);
  localparam int FW = $clog2(SLOTS + 1);
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [9:0]    X_SCAN   = 10'(H_VISIBLE);
  localparam logic [9:0]    X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_TERR - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WAIT, S_COMMIT} state_t;

  state_t state, next_state;

  logic [70:0]   terr_arr [NUM_TERR];
  logic [70:0]   rec;
  logic [IW-1:0] idx;
  logic [9:0]    y_next;
  logic          blank;
  logic [FW-1:0] fill;
  logic          sh_ovf;
  logic [9:0]    sh_x      [SLOTS];
  logic [3:0]    sh_row    [SLOTS];
  logic [6:0]    sh_char   [SLOTS];
  logic [1:0]    sh_color  [SLOTS];
  logic [6:0]    sh_troops [SLOTS];

  logic          start, commit_now, hit, unused_rec;
  logic [10:0]   yn_ext, y_lo, y_hi;

  for (genvar g = 0; g < NUM_TERR; g++) begin : g_unpack
    assign terr_arr[g] = territories[g*71 +: 71];
  end

  assign rec        = terr_arr[idx];
  assign unused_rec = ^rec[70:35];
  assign start      = (state == S_IDLE) && (DrawX == X_SCAN);
  assign commit_now = (state == S_WAIT) && (DrawX == X_LAST);
  assign state_dbg  = state;

  // Intersection test widened to 11 bits so y near 511 plus CHAR_H never wraps.
  assign yn_ext = {1'b0, y_next};
  assign y_lo   = {2'b00, rec[27:19]};
  assign y_hi   = y_lo + 11'(CHAR_H);
  assign hit    = (yn_ext >= y_lo) && (yn_ext < y_hi);

  // State register.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next-state logic: scan starts at hblank, waits for line end, commits once.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_SCAN;
      S_SCAN:   if (idx == IDX_LAST) next_state = S_WAIT;
      S_WAIT:   if (commit_now) next_state = S_COMMIT;
      S_COMMIT: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Shadow buffer: cleared at the latch cycle, filled in ascending index order.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      idx    <= '0;
      y_next <= '0;
      blank  <= 1'b0;
      fill   <= '0;
      sh_ovf <= 1'b0;
      for (int k = 0; k < SLOTS; k++) begin
        sh_x[k] <= '0; sh_row[k] <= '0; sh_char[k] <= '0;
        sh_color[k] <= '0; sh_troops[k] <= '0;
      end
    end else if (start) begin
      idx    <= '0;
      y_next <= (DrawY == Y_LAST) ? 10'd0 : DrawY + 10'd1;
      blank  <= setup | vic_on;
      fill   <= '0;
      sh_ovf <= 1'b0;
      for (int k = 0; k < SLOTS; k++) begin
        sh_x[k] <= '0; sh_row[k] <= '0; sh_char[k] <= '0;
        sh_color[k] <= '0; sh_troops[k] <= '0;
      end
    end else if (state == S_SCAN) begin
      idx <= idx + 1'b1;
      if (hit && !blank) begin
        if (fill < FW'(SLOTS)) begin
          sh_x[fill[SW-1:0]]      <= rec[18:9];
          sh_row[fill[SW-1:0]]    <= y_next[3:0] - rec[22:19];
          sh_char[fill[SW-1:0]]   <= rec[6:0];
          sh_color[fill[SW-1:0]]  <= rec[8:7];
          sh_troops[fill[SW-1:0]] <= rec[34:28];
          fill <= fill + 1'b1;
        end else begin
          sh_ovf <= 1'b1;
        end
      end
    end
  end

  // Published slots: copied from the shadow on the last pixel of the line.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid  <= '0;
      slot_x      <= '0;
      slot_row    <= '0;
      slot_char   <= '0;
      slot_color  <= '0;
      slot_troops <= '0;
      overflow    <= 1'b0;
      scan_done   <= 1'b0;
    end else begin
      scan_done <= commit_now;
      if (commit_now) begin
        overflow <= sh_ovf;
        for (int k = 0; k < SLOTS; k++) begin
          slot_valid[k]           <= (FW'(k) < fill);
          slot_x[k*10 +: 10]      <= sh_x[k];
          slot_row[k*4 +: 4]      <= sh_row[k];
          slot_char[k*7 +: 7]     <= sh_char[k];
          slot_color[k*2 +: 2]    <= sh_color[k];
          slot_troops[k*7 +: 7]   <= sh_troops[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_territory_label_scheduler.sv
// Bench for territory_label_scheduler: drives a raster counter line by line,
// predicts each committed slot set from a reference model, and checks the
// table of per-line expectations plus reset and stability sequences.
module tb_territory_label_scheduler;

  localparam int NT = 42;
  localparam int SL = 4;

  logic               vga_clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [9:0]         DrawX = '0;
  logic [9:0]         DrawY = '0;
  logic               setup = 1'b0;
  logic               vic_on = 1'b0;
  logic [71*NT-1:0]   territories = '0;
  logic [SL-1:0]      slot_valid;
  logic [10*SL-1:0]   slot_x;
  logic [4*SL-1:0]    slot_row;
  logic [7*SL-1:0]    slot_char;
  logic [2*SL-1:0]    slot_color;
  logic [7*SL-1:0]    slot_troops;
  logic               scan_done;
  logic               overflow;
  logic [1:0]         state_dbg;

  territory_label_scheduler dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .setup(setup), .vic_on(vic_on), .territories(territories),
    .slot_valid(slot_valid), .slot_x(slot_x), .slot_row(slot_row),
    .slot_char(slot_char), .slot_color(slot_color), .slot_troops(slot_troops),
    .scan_done(scan_done), .overflow(overflow), .state_dbg(state_dbg)
  );

  // Clock
  always #5 vga_clk = ~vga_clk;

  int tx[NT], ty[NT], tc[NT], tcol[NT], ttr[NT];
  int checks = 0;
  int errors = 0;
  int pulse_cnt;
  logic [124:0] exp_q[$];
  logic [124:0] act_vec;

  assign act_vec = {slot_valid, slot_x, slot_row, slot_char, slot_color, slot_troops, overflow};

  typedef struct {
    int         dy;
    bit         s;
    bit         v;
    logic [3:0] ev;
    logic       eo;
    logic [3:0] er;
  } vec_t;

  vec_t vecs[14];

  // Reference model of one committed line.
  function automatic logic [124:0] model(input int dy, input bit blk);
    int yn, fill;
    logic [3:0]  v;
    logic [39:0] x;
    logic [15:0] r;
    logic [27:0] c;
    logic [7:0]  co;
    logic [27:0] t;
    logic        o;
    yn = (dy == 524) ? 0 : dy + 1;
    fill = 0; v = '0; x = '0; r = '0; c = '0; co = '0; t = '0; o = 1'b0;
    for (int i = 0; i < NT; i++) begin
      if (!blk && yn >= ty[i] && yn < ty[i] + 16) begin
        if (fill < SL) begin
          v[fill]          = 1'b1;
          x[fill*10 +: 10] = 10'(tx[i]);
          r[fill*4 +: 4]   = 4'(yn - ty[i]);
          c[fill*7 +: 7]   = 7'(tc[i]);
          co[fill*2 +: 2]  = 2'(tcol[i]);
          t[fill*7 +: 7]   = 7'(ttr[i]);
          fill++;
        end else begin
          o = 1'b1;
        end
      end
    end
    return {v, x, r, c, co, t, o};
  endfunction

  task automatic pack_terr();
    for (int i = 0; i < NT; i++)
      territories[i*71 +: 71] = {4'h0, 32'($urandom), 7'(ttr[i]), 9'(ty[i]),
                                 10'(tx[i]), 2'(tcol[i]), 7'(tc[i])};
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every scan_done pops one predicted slot set.
  task automatic sample_done();
    if (scan_done) begin
      pulse_cnt++;
      if (exp_q.size() == 0) check("scan_done_unexpected", 128'(scan_done), 128'd0);
      else check("commit_slots", 128'(act_vec), 128'(exp_q.pop_front()));
    end
  endtask

  task automatic step(input int x);
    DrawX = 10'(x);
    @(posedge vga_clk);
    #1;
    sample_done();
  endtask

  task automatic run_line(input int dy, input bit s, input bit v, input bit exp_commit);
    logic [124:0] snap;
    bit stable;
    DrawY = 10'(dy); setup = s; vic_on = v;
    if (exp_commit) exp_q.push_back(model(dy, s | v));
    snap = act_vec;
    stable = 1'b1;
    pulse_cnt = 0;
    for (int x = 0; x < 800; x++) begin
      step(x);
      if (x <= 638 && act_vec !== snap) stable = 1'b0;
    end
    check("stable_visible", 128'(stable), 128'd1);
    check("scan_done_pulses", 128'(pulse_cnt), exp_commit ? 128'd1 : 128'd0);
  endtask

  initial begin
    for (int i = 0; i < NT; i++) begin
      tx[i] = $urandom_range(0, 620);
      ty[i] = 400;
      tc[i] = $urandom_range(0, 127);
      tcol[i] = $urandom_range(0, 3);
      ttr[i] = $urandom_range(0, 127);
    end
    ty[2] = 100; ty[7] = 100; ty[30] = 100;
    for (int i = 10; i <= 15; i++) ty[i] = 200;
    ty[5] = 0; ty[20] = 509; ty[25] = 300;
    pack_terr();

    vecs[0]  = '{104, 0, 0, 4'b0111, 1'b0, 4'd5};
    vecs[1]  = '{199, 0, 0, 4'b1111, 1'b1, 4'd0};
    vecs[2]  = '{250, 0, 0, 4'b0000, 1'b0, 4'd0};
    vecs[3]  = '{524, 0, 0, 4'b0001, 1'b0, 4'd0};
    vecs[4]  = '{508, 0, 0, 4'b0001, 1'b0, 4'd0};
    vecs[5]  = '{523, 0, 0, 4'b0001, 1'b0, 4'd15};
    vecs[6]  = '{507, 0, 0, 4'b0000, 1'b0, 4'd0};
    vecs[7]  = '{299, 0, 0, 4'b0001, 1'b0, 4'd0};
    vecs[8]  = '{314, 0, 0, 4'b0001, 1'b0, 4'd15};
    vecs[9]  = '{298, 0, 0, 4'b0000, 1'b0, 4'd0};
    vecs[10] = '{315, 0, 0, 4'b0000, 1'b0, 4'd0};
    vecs[11] = '{104, 1, 0, 4'b0000, 1'b0, 4'd0};
    vecs[12] = '{199, 0, 1, 4'b0000, 1'b0, 4'd0};
    vecs[13] = '{110, 0, 0, 4'b0111, 1'b0, 4'd11};

    // Reset block
    repeat (3) @(posedge vga_clk);
    #1;
    check("reset_outputs", 128'(act_vec), 128'd0);
    check("reset_scan_done", 128'(scan_done), 128'd0);
    reset_n = 1'b1;

    // Table-driven lines
    for (int i = 0; i < 14; i++) begin
      run_line(vecs[i].dy, vecs[i].s, vecs[i].v, 1'b1);
      check($sformatf("valid_%0d", i), 128'(slot_valid), 128'(vecs[i].ev));
      check($sformatf("overflow_%0d", i), 128'(overflow), 128'(vecs[i].eo));
      check($sformatf("row0_%0d", i), 128'(slot_row[3:0]), 128'(vecs[i].er));
    end

    // Reset in the middle of a scan: outputs clear at once, no commit follows.
    DrawY = 10'd104; setup = 1'b0; vic_on = 1'b0;
    pulse_cnt = 0;
    for (int x = 0; x <= 660; x++) step(x);
    reset_n = 1'b0;
    #1;
    check("midscan_reset_outputs", 128'(act_vec), 128'd0);
    check("midscan_reset_scan_done", 128'(scan_done), 128'd0);
    for (int x = 661; x <= 663; x++) step(x);
    reset_n = 1'b1;
    for (int x = 664; x < 800; x++) step(x);
    check("aborted_line_pulses", 128'(pulse_cnt), 128'd0);
    check("aborted_line_valid", 128'(slot_valid), 128'd0);

    // Next full line scans from scratch and commits.
    run_line(104, 1'b0, 1'b0, 1'b1);
    check("post_reset_valid", 128'(slot_valid), 128'(4'b0111));
    check("post_reset_row0", 128'(slot_row[3:0]), 128'd5);
    check("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
